// File: rtl/dino_pkg.sv
// dino_pkg: shared game states, BCD digit type and default tuning constants
package dino_pkg;
  typedef enum logic [1:0] {IDLE, RUN, OVER} game_state_t;
  typedef logic [3:0] bcd_digit_t;
  localparam int COLL_MIN_D  = 4;
  localparam int SCORE_DIV_D = 6;
  localparam int OVER_HOLD_D = 30;
endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: four-digit BCD score that increments by one and saturates at 9999
module bcd_counter4
  import dino_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] score
);
  logic [15:0] nxt;
  logic        carry;
  bcd_digit_t  d;
  // ripple the +1 through the digits, each wrapping 9 -> 0 into the next
  always_comb begin
    nxt = score;
    carry = 1'b1;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d = score[4*i +: 4];
      nxt[4*i +: 4] = carry ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
      carry = carry && d == 4'd9;
    end
  end
  // clear has priority; 9999 is a ceiling, not a wrap point
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) score <= '0;
    else score <= clr ? '0 : (inc && score != 16'h9999) ? nxt : score;
endmodule

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: frame-based collision detection, IDLE/RUN/OVER game flow and BCD score
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int COLL_MIN  = COLL_MIN_D,
  parameter int SCORE_DIV = SCORE_DIV_D,
  parameter int OVER_HOLD = OVER_HOLD_D
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        fresh,
  input  logic        video_on,
  input  logic        dino_px,
  input  logic        obst_px,
  input  logic        button_jump,
  output logic        game_status,
  output logic        game_over,
  output logic        hit,
  output logic [15:0] score
);
  localparam logic [7:0] C_MIN   = 8'(COLL_MIN);
  localparam logic [7:0] DIV_TOP = 8'(SCORE_DIV - 1);
  localparam logic [7:0] HOLD    = 8'(OVER_HOLD);
  game_state_t state, state_n;
  logic       b1, b2, b3, f1, f2;
  logic       btn_rise, frame_tick, ov;
  logic [7:0] ov_cnt, div, div_n, hold, hold_n;
  logic       hit_n, clr, inc;
  assign btn_rise    = b2 & ~b3;
  assign frame_tick  = f2 & ~f1;
  assign ov          = dino_px & obst_px & video_on;
  assign game_status = state == RUN;
  assign game_over   = state == OVER;
  // button synchronizer plus edge history for the button and the frame strobe
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) {b1, b2, b3, f1, f2} <= '0;
    else {b1, b2, b3, f1, f2} <= {button_jump, b1, b2, fresh, f1};
  // overlap pixels of the current frame; a pixel on the tick cycle opens the new frame
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) ov_cnt <= '0;
    else ov_cnt <= state != RUN ? '0 : frame_tick ? {7'd0, ov} : ov_cnt + {7'd0, ov && ov_cnt != 8'hff};
  // state, frame divider, restart hold and hit pulse registers
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      div <= '0;
      hold <= '0;
      hit <= 1'b0;
    end else begin
      state <= state_n;
      div <= div_n;
      hold <= hold_n;
      hit <= hit_n;
    end
  // game flow: a transition swallows any tick arriving with it, collision beats scoring
  always_comb begin
    state_n = state;
    div_n = div;
    hold_n = hold;
    hit_n = 1'b0;
    clr = 1'b0;
    inc = 1'b0;
    case (state)
      IDLE:
        if (btn_rise) begin
          state_n = RUN;
          clr = 1'b1;
          div_n = '0;
        end
      RUN:
        if (frame_tick) begin
          if (ov_cnt >= C_MIN) begin
            state_n = OVER;
            hit_n = 1'b1;
            hold_n = '0;
          end else begin
            inc = div == DIV_TOP;
            div_n = inc ? '0 : div + 8'd1;
          end
        end
      OVER:
        if (btn_rise && hold == HOLD) begin
          state_n = RUN;
          clr = 1'b1;
          div_n = '0;
        end else if (frame_tick && hold != HOLD) hold_n = hold + 8'd1;
      default: state_n = IDLE;
    endcase
  end
  bcd_counter4 u_score (
    .CLK  (CLK),
    .RESET(RESET),
    .clr  (clr),
    .inc  (inc),
    .score(score)
  );
endmodule

// File: doc/dino_game_ctrl.md
# dino_game_ctrl

Game-state controller and collision detector that sits directly downstream of the dinosaur sprite renderer and the obstacle renderer. Each pixel clock it ANDs the dinosaur pixel stream with the obstacle pixel stream. At every frame boundary it decides whether a collision occurred, runs the IDLE/RUN/OVER game state machine, and keeps a BCD score. Its `game_status` output feeds back into the sprite renderer to enable jump motion.

## Interface
Parameters:
- `COLL_MIN`, default 4: minimum count of overlapping pixels in one frame that declares a collision (1..255).
- `SCORE_DIV`, default 6: number of RUN frames per score increment (1..255).
- `OVER_HOLD`, default 30: number of frames in OVER before a restart press is accepted (0..255).

Ports:
- `CLK` in 1: pixel clock. Reset `RESET`, asynchronous, active-high; clock `CLK`.
- `RESET` in 1: asynchronous, active-high; all state returns to IDLE.
- `fresh` in 1: frame strobe from the VGA timing block; its falling edge marks a frame boundary.
- `video_on` in 1: high while the current pixel is in the visible area.
- `dino_px` in 1: dinosaur sprite pixel for the current address.
- `obst_px` in 1: obstacle sprite pixel for the current address.
- `button_jump` in 1: raw, asynchronous push button.
- `game_status` out 1: high only in RUN.
- `game_over` out 1: high only in OVER.
- `hit` out 1: one-cycle pulse on the RUN→OVER transition.
- `score` out 16: four BCD digits, with digit 3 at [15:12].

## Operation
- **Button input.** `button_jump` passes through a 2-FF synchronizer. A rising-edge detector on the synchronized signal produces `btn_rise`, a one-cycle pulse.
- **Frame tick.** `fresh` is registered once. `frame_tick` is asserted for one cycle when the previous sample is 1 and the current sample is 0.
- **Overlap counter.** The counter is 8 bits and saturates at 255. Each cycle, `ov = dino_px & obst_px & video_on` increments it.
  - On a `frame_tick` cycle, the counter loads `ov` (0 or 1). A pixel arriving on the tick cycle therefore belongs to the new frame.
  - The counter is held at 0 outside RUN.
- **State machine, IDLE** (reset state):
  - Outputs: `game_status`=0, `game_over`=0.
  - `btn_rise` moves to RUN. On that transition the score clears to 0000 and the frame divider clears to 0.
- **State machine, RUN:**
  - Outputs: `game_status`=1.
  - On `frame_tick`, if overlap_count ≥ `COLL_MIN`, go to OVER, pulse `hit`, and clear the hold counter.
  - Otherwise on `frame_tick`, increment the frame divider. When the divider reaches `SCORE_DIV`-1, it wraps to 0 and the score increments.
  - `btn_rise` is ignored in RUN.
- **State machine, OVER:**
  - Outputs: `game_over`=1; the score is frozen.
  - The hold counter increments on each `frame_tick` and saturates at `OVER_HOLD`.
  - `btn_rise` while hold counter = `OVER_HOLD` moves to RUN, clearing the score, divider and overlap counter.
  - An earlier `btn_rise` is discarded, not queued.
- **Score.** The score is a 4-digit BCD ripple count. Each digit wraps 9→0 with a carry into the next digit. At 9999 the score saturates and does not wrap.

## Timing
- **Reset values:**
  - state IDLE;
  - `game_status`=0, `game_over`=0, `hit`=0, `score`=16'h0000;
  - all counters 0;
  - synchronizer and edge registers 0.
- All outputs are registered and change on the `CLK` edge after the decision cycle.
  - The `fresh` falling edge reaches `frame_tick` 1 cycle after it is sampled.
  - State, `hit` and `score` update on the cycle after `frame_tick`.
- `button_jump` to state change takes 3 `CLK` cycles: 2 synchronizer stages plus 1 edge stage, then the state register.
- **Simultaneous events:**
  - `frame_tick` together with `btn_rise` in IDLE or OVER: the state transition wins, and that tick does not count toward the hold or score.
  - A collision decision and a score increment on the same tick: collision wins and the score is not incremented.
- **Reset mid-frame:** the asynchronous reset clears everything immediately. The first `frame_tick` after release starts a clean frame.
- **`OVER_HOLD`=0:** a restart is allowed on the first `btn_rise` in OVER.

## Structure
- Shared package `dino_pkg`:
  - the state enum `game_state_t` {IDLE, RUN, OVER};
  - the BCD digit type (4-bit);
  - default constants `COLL_MIN_D`, `SCORE_DIV_D`, `OVER_HOLD_D`, shared with the renderer top level.
- Sub-module `bcd_counter4`: ports `CLK`, `RESET`, `clr`, `inc`, `score[15:0]`. It holds the saturating 4-digit BCD increment. The edge detectors and the FSM stay in the top module.

## Test plan
- **Start and score:** reset, assert `button_jump`, no overlap, run 60 frames with `SCORE_DIV`=6 → `game_status`=1 within 4 cycles of the press; `score`=16'h0010 after 60 ticks.
- **Collision threshold:** in RUN, drive 3 overlap pixels in frame N and 4 in frame N+1 with `COLL_MIN`=4 → frame N continues; at the tick ending N+1, `hit` pulses once and `game_over`=1. Pixels with `video_on`=0 are not counted.
- **Restart hold:** in OVER with `OVER_HOLD`=30, press at frame 10 → ignored. Press at frame 31 → RUN, `score`=16'h0000.
- **Saturation:** preload a score near 9999 via long RUN (or force), with further ticks → BCD carries 0099→0100, and the score stays at 9999 after the limit.
- **Tick-edge overlap:** an overlap pixel on the exact `frame_tick` cycle → counted in the next frame, not the ending one.
- **Reset mid-RUN:** assert RESET asynchronously between clock edges → all outputs 0 immediately, state IDLE; the next press restarts cleanly.
